tx_frame_sequencer: RTL

//  Upstream sequencer for the 4:1 dibit mux encoder in the Tx path. Accepts payload bytes over a

---
 rtl/tx_frame_sequencer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer
//   Feeds the 4:1 dibit mux of the Tx path. Each frame is sent as a preamble,
//   then the payload bytes, then an XOR checksum, one dibit per clock. The
//   mux selects {sB,sA} pick in0 = preamble, in1 = payload, in2 = checksum.
//   Select 11 (idle and payload stall) makes the mux output 0.
//   Every output except tx_ready is registered. Each output register is fed
//   from the next-state values, so a symbol appears on the same edge that
//   enters its state.
//   PREAMBLE_DIBITS must be in the range 1..16.
module tx_frame_sequencer #(
  parameter int unsigned PREAMBLE_DIBITS  = 4,
  parameter logic [1:0]  PREAMBLE_PATTERN = 2'b10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       sB,
  output logic       sA,
  output logic [1:0] pre_dibit,
  output logic [1:0] data_dibit,
  output logic [1:0] chk_dibit,
  output logic       busy,
  output logic       underrun,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(17);
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PREAMBLE_DIBITS - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_PAY  = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_CHK  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       chk_q, chk_d;
  logic             last_q, last_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] sel_q, sel_d;
  logic [1:0] pre_dibit_q, pre_dibit_d;
  logic [1:0] data_dibit_q, data_dibit_d;
  logic [1:0] chk_dibit_q, chk_dibit_d;
  logic       busy_q, busy_d;
  logic       underrun_q, underrun_d;
  logic       frame_done_q, frame_done_d;

  // Ready is decoded from the current state: idle, stalled, or on the last
  // dibit of a byte that is not the frame's final byte.
  always_comb begin
    tx_ready = 1'b0;
    case (state_q)
      ST_IDLE: tx_ready = 1'b1;
      ST_WAIT: tx_ready = 1'b1;
      ST_PAY:  tx_ready = (idx_q == 2'd3) && !last_q;
      default: tx_ready = 1'b0;
    endcase
  end

  // Frame sequencing: state transitions, shift register, checksum and counters.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    chk_d      = chk_q;
    last_d     = last_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    underrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          // The checksum of a new frame starts from the first byte itself.
          shreg_d = tx_data;
          chk_d   = tx_data;
          last_d  = tx_last;
          idx_d   = 2'd0;
          cnt_d   = PRE_LOAD;
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        if (cnt_q == '0) begin
          idx_d   = 2'd0;
          state_d = ST_PAY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PAY: begin
        if (idx_q != 2'd3) begin
          shreg_d = {shreg_q[5:0], 2'b00};
          idx_d   = idx_q + 2'd1;
        end else if (last_q) begin
          // chk_q is left intact so its MSB dibit goes out first.
          idx_d   = 2'd0;
          state_d = ST_CHK;
        end else if (tx_valid) begin
          // Back-to-back byte: continue with no gap.
          shreg_d = tx_data;
          chk_d   = chk_q ^ tx_data;
          last_d  = tx_last;
          idx_d   = 2'd0;
        end else begin
          idx_d      = 2'd0;
          underrun_d = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_valid) begin
          shreg_d = tx_data;
          chk_d   = chk_q ^ tx_data;
          last_d  = tx_last;
          idx_d   = 2'd0;
          state_d = ST_PAY;
        end
      end
      ST_CHK: begin
        chk_d = {chk_q[5:0], 2'b00};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, taken from the next state so that
  // each registered symbol lines up with the state that produces it.
  always_comb begin
    sel_d        = 2'b11;
    pre_dibit_d  = 2'b00;
    data_dibit_d = 2'b00;
    chk_dibit_d  = 2'b00;
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = 1'b0;
    case (state_d)
      ST_PRE: begin
        sel_d       = 2'b00;
        pre_dibit_d = PREAMBLE_PATTERN;
      end
      ST_PAY: begin
        sel_d        = 2'b01;
        data_dibit_d = shreg_d[7:6];
      end
      ST_CHK: begin
        sel_d        = 2'b10;
        chk_dibit_d  = chk_d[7:6];
        frame_done_d = (idx_d == 2'd3);
      end
      default: begin
        sel_d = 2'b11;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= 8'h00;
      chk_q   <= 8'h00;
      last_q  <= 1'b0;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      chk_q   <= chk_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered mux selects, dibits and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q        <= 2'b11;
      pre_dibit_q  <= 2'b00;
      data_dibit_q <= 2'b00;
      chk_dibit_q  <= 2'b00;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      pre_dibit_q  <= pre_dibit_d;
      data_dibit_q <= data_dibit_d;
      chk_dibit_q  <= chk_dibit_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sB         = sel_q[1];
  assign sA         = sel_q[0];
  assign pre_dibit  = pre_dibit_q;
  assign data_dibit = data_dibit_q;
  assign chk_dibit  = chk_dibit_q;
  assign busy       = busy_q;
  assign underrun   = underrun_q;
  assign frame_done = frame_done_q;

endmodule
